// File: rtl/ebpc_pkg.sv
// Shared types and helpers for the EBPC compressor stages.
// Holds the zero run-length state encoding and the run-symbol field builder.
package ebpc_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } zrle_state_t;

    localparam int ZRLE_DEF_DATA_W = 8;
    localparam int ZRLE_LEN_W      = $clog2(ZRLE_DEF_DATA_W + 2);

    // Run of n zeros is coded as (n-1) in a log_max-bit field; n == 2**log_max wraps to all ones.
    function automatic logic [63:0] zrle_run_symb(input logic [31:0] n, input int unsigned log_max);
        logic [63:0] mask;
        mask = (64'd1 << log_max) - 64'd1;
        return {32'd0, n - 32'd1} & mask;
    endfunction

endpackage

// File: rtl/ebpc_sym_reg.sv
// One-entry valid/ready holding register for a {symbol, length, last} triple.
// Accepts a new entry whenever it is empty or its current entry is being taken.
module ebpc_sym_reg #(
    parameter int SYMB_W = 9,
    parameter int LEN_W  = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              in_vld_i,
    output logic              in_rdy_o,
    input  logic [SYMB_W-1:0] in_symb_i,
    input  logic [LEN_W-1:0]  in_len_i,
    input  logic              in_last_i,
    output logic              out_vld_o,
    input  logic              out_rdy_i,
    output logic [SYMB_W-1:0] out_symb_o,
    output logic [LEN_W-1:0]  out_len_o,
    output logic              out_last_o
);

    logic              vld_q;
    logic [SYMB_W-1:0] symb_q;
    logic [LEN_W-1:0]  len_q;
    logic              last_q;

    assign in_rdy_o   = !vld_q || out_rdy_i;
    assign out_vld_o  = vld_q;
    assign out_symb_o = symb_q;
    assign out_len_o  = len_q;
    assign out_last_o = last_q;

    // Payload only changes on a load so it stays stable while stalled.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_q  <= 1'b0;
            symb_q <= '0;
            len_q  <= '0;
            last_q <= 1'b0;
        end else if (in_rdy_o) begin
            vld_q <= in_vld_i;
            if (in_vld_i) begin
                symb_q <= in_symb_i;
                len_q  <= in_len_i;
                last_q <= in_last_i;
            end
        end
    end

endmodule

// File: rtl/ebpc_zrle_encoder.sv
// Zero run-length encoder: nonzero words become literals, zero runs become run symbols.
// Optional statistics counters are built when EBPC_ZRLE_STATS_EN is defined.
module ebpc_zrle_encoder
    import ebpc_pkg::*;
#(
    parameter  int DATA_W           = 8,
    parameter  int LOG_MAX_ZRLE_LEN = 4,
    localparam int SYMB_W           = DATA_W + 1,
    localparam int LEN_W            = $clog2(SYMB_W + 1)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [DATA_W-1:0] data_i,
    input  logic              last_i,
    input  logic              vld_i,
    output logic              rdy_o,
    output logic [SYMB_W-1:0] symb_o,
    output logic [LEN_W-1:0]  len_o,
    output logic              last_o,
    output logic              vld_o,
    input  logic              rdy_i
`ifdef EBPC_ZRLE_STATS_EN
    ,
    input  logic              clr_stats_i,
    output logic [31:0]       n_words_o,
    output logic [31:0]       n_bits_o
`endif
);

    localparam int                CNT_W    = LOG_MAX_ZRLE_LEN + 1;
    localparam int                MAX_RUN  = 2 ** LOG_MAX_ZRLE_LEN;
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(MAX_RUN);
    localparam logic [LEN_W-1:0]  LIT_LEN  = LEN_W'(SYMB_W);
    localparam logic [LEN_W-1:0]  RUN_LEN  = LEN_W'(LOG_MAX_ZRLE_LEN + 1);
    localparam int unsigned       LOG_U    = LOG_MAX_ZRLE_LEN;

    zrle_state_t       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  cnt_inc_s;
    logic              zero_s;
    logic              close_s;
    logic              can_emit_s;
    logic              rdy_s;
    logic              emit_vld_s;
    logic [SYMB_W-1:0] emit_symb_s;
    logic [LEN_W-1:0]  emit_len_s;
    logic              emit_last_s;
    logic [SYMB_W-1:0] run_one_s, run_cur_s, run_next_s;

    assign zero_s     = (data_i == '0);
    assign cnt_inc_s  = cnt_q + CNT_ONE;
    assign close_s    = (cnt_inc_s == CNT_MAX) || last_i;
    assign run_one_s  = SYMB_W'(zrle_run_symb(32'd1, LOG_U));
    assign run_cur_s  = SYMB_W'(zrle_run_symb(32'(cnt_q), LOG_U));
    assign run_next_s = SYMB_W'(zrle_run_symb(32'(cnt_inc_s), LOG_U));
    assign rdy_o      = rdy_s;

    // Next-state, input ready and symbol to emit.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rdy_s       = 1'b0;
        emit_vld_s  = 1'b0;
        emit_symb_s = '0;
        emit_len_s  = '0;
        emit_last_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (zero_s && !last_i) begin
                    // A run can start even while the output register is stalled.
                    rdy_s = 1'b1;
                    if (vld_i) begin
                        cnt_d   = CNT_ONE;
                        state_d = RUN;
                    end else begin
                        cnt_d   = cnt_q;
                    end
                end else if (zero_s) begin
                    rdy_s       = can_emit_s;
                    emit_vld_s  = vld_i && can_emit_s;
                    emit_symb_s = run_one_s;
                    emit_len_s  = RUN_LEN;
                    emit_last_s = 1'b1;
                end else begin
                    rdy_s       = can_emit_s;
                    emit_vld_s  = vld_i && can_emit_s;
                    emit_symb_s = {1'b1, data_i};
                    emit_len_s  = LIT_LEN;
                    emit_last_s = last_i;
                end
            end
            RUN: begin
                if (zero_s && close_s) begin
                    rdy_s       = can_emit_s;
                    emit_vld_s  = vld_i && can_emit_s;
                    emit_symb_s = run_next_s;
                    emit_len_s  = RUN_LEN;
                    emit_last_s = last_i;
                    if (emit_vld_s) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        state_d = RUN;
                    end
                end else if (zero_s) begin
                    rdy_s = 1'b1;
                    if (vld_i) begin
                        cnt_d = cnt_inc_s;
                    end else begin
                        cnt_d = cnt_q;
                    end
                end else begin
                    // Close the run first; the literal is taken afterwards from IDLE.
                    rdy_s       = 1'b0;
                    emit_vld_s  = vld_i && can_emit_s;
                    emit_symb_s = run_cur_s;
                    emit_len_s  = RUN_LEN;
                    emit_last_s = 1'b0;
                    if (emit_vld_s) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // FSM state and pending run length.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    ebpc_sym_reg #(
        .SYMB_W (SYMB_W),
        .LEN_W  (LEN_W)
    ) u_sym_reg (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .in_vld_i   (emit_vld_s),
        .in_rdy_o   (can_emit_s),
        .in_symb_i  (emit_symb_s),
        .in_len_i   (emit_len_s),
        .in_last_i  (emit_last_s),
        .out_vld_o  (vld_o),
        .out_rdy_i  (rdy_i),
        .out_symb_o (symb_o),
        .out_len_o  (len_o),
        .out_last_o (last_o)
    );

`ifdef EBPC_ZRLE_STATS_EN
    logic [31:0] n_words_q, n_words_d;
    logic [31:0] n_bits_q, n_bits_d;
    logic [32:0] bits_sum_s;

    assign n_words_o = n_words_q;
    assign n_bits_o  = n_bits_q;

    // Saturating word/bit counters; clear wins over counting.
    always_comb begin
        n_words_d  = n_words_q;
        n_bits_d   = n_bits_q;
        bits_sum_s = {1'b0, n_bits_q} + 33'(len_o);
        if (clr_stats_i) begin
            n_words_d = 32'd0;
            n_bits_d  = 32'd0;
        end else begin
            if (vld_i && rdy_s && (n_words_q != 32'hFFFF_FFFF)) begin
                n_words_d = n_words_q + 32'd1;
            end else begin
                n_words_d = n_words_q;
            end
            if (vld_o && rdy_i) begin
                n_bits_d = bits_sum_s[32] ? 32'hFFFF_FFFF : bits_sum_s[31:0];
            end else begin
                n_bits_d = n_bits_q;
            end
        end
    end

    // Statistics registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            n_words_q <= 32'd0;
            n_bits_q  <= 32'd0;
        end else begin
            n_words_q <= n_words_d;
            n_bits_q  <= n_bits_d;
        end
    end
`endif

endmodule

// File: tb/tb_ebpc_zrle_encoder.sv
// Self-checking bench for ebpc_zrle_encoder (DATA_W=8, LOG_MAX_ZRLE_LEN=4) with a queue-based reference model.
module tb_ebpc_zrle_encoder;

    localparam int MAXR = 16;

    typedef struct packed {
        logic [8:0] symb;
        logic [3:0] len;
        logic       last;
    } sym_t;

    logic       clk = 1'b0;
    logic       rst_ni;
    logic [7:0] data_i;
    logic       last_i;
    logic       vld_i;
    logic       rdy_o;
    logic [8:0] symb_o;
    logic [3:0] len_o;
    logic       last_o;
    logic       vld_o;
    logic       rdy_i;
`ifdef EBPC_ZRLE_STATS_EN
    logic        clr_stats_i;
    logic [31:0] n_words_o;
    logic [31:0] n_bits_o;
`endif

    int   checks = 0;
    int   errors = 0;
    int   run_cnt = 0;
    bit   rdy_rand = 1'b0;
    bit   stall_v = 1'b0;
    sym_t held;
    sym_t exp_q[$];
    sym_t obs_q[$];

    ebpc_zrle_encoder #(
        .DATA_W           (8),
        .LOG_MAX_ZRLE_LEN (4)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .data_i      (data_i),
        .last_i      (last_i),
        .vld_i       (vld_i),
        .rdy_o       (rdy_o),
        .symb_o      (symb_o),
        .len_o       (len_o),
        .last_o      (last_o),
        .vld_o       (vld_o),
        .rdy_i       (rdy_i)
`ifdef EBPC_ZRLE_STATS_EN
        ,
        .clr_stats_i (clr_stats_i),
        .n_words_o   (n_words_o),
        .n_bits_o    (n_bits_o)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h @%0t", name, act, exp, $time);
        end
    endtask

    function automatic sym_t run_sym(input int n, input bit l);
        sym_t s;
        s.symb = 9'(n - 1);
        s.len  = 4'd5;
        s.last = l;
        return s;
    endfunction

    function automatic sym_t lit_sym(input logic [7:0] w, input bit l);
        sym_t s;
        s.symb = {1'b1, w};
        s.len  = 4'd9;
        s.last = l;
        return s;
    endfunction

    // Reference: symbols implied by the accepted word sequence.
    task automatic model_word(input logic [7:0] w, input bit l);
        if (w == 8'd0) begin
            run_cnt++;
            if (run_cnt == MAXR || l) begin
                exp_q.push_back(run_sym(run_cnt, l));
                run_cnt = 0;
            end
        end else begin
            if (run_cnt > 0) exp_q.push_back(run_sym(run_cnt, 1'b0));
            run_cnt = 0;
            exp_q.push_back(lit_sym(w, l));
        end
    endtask

    // Monitor at the inactive edge: feeds the model and compares each output transfer.
    always @(negedge clk) begin
        sym_t cur;
        sym_t e;
        cur = '{symb: symb_o, len: len_o, last: last_o};
        if (!rst_ni) begin
            exp_q.delete();
            run_cnt = 0;
            stall_v = 1'b0;
        end else begin
            if (stall_v) begin
                check("hold_vld", 32'(vld_o), 32'd1);
                check("hold_sym", 32'(cur), 32'(held));
            end
            if (vld_i && rdy_o) model_word(data_i, last_i);
            if (vld_o && rdy_i) begin
                obs_q.push_back(cur);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_sym actual=%h expected=none", cur);
                end else begin
                    e = exp_q.pop_front();
                    check("model_sym", 32'(cur), 32'(e));
                end
            end
            stall_v = vld_o && !rdy_i;
            held    = cur;
        end
    end

    always @(posedge clk) begin
        #2;
        if (rdy_rand) rdy_i = 1'($urandom_range(0, 1));
    end

    // All stimulus tasks start and end 2 time units after a rising edge.
    task automatic send(input logic [7:0] w, input bit l, output int waits);
        bit done;
        done   = 1'b0;
        waits  = 0;
        data_i = w;
        last_i = l;
        vld_i  = 1'b1;
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge clk);
            if (rdy_o) done = 1'b1;
            else waits++;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL send_timeout actual=no_accept expected=accept data=%h", w);
        end
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        vld_i  = 1'b0;
        last_i = 1'b0;
        data_i = 8'd0;
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        vld_i  = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_ni = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        rst_ni = 1'b0;
        vld_i  = 1'b0;
        data_i = 8'd0;
        last_i = 1'b0;
        rdy_i  = 1'b1;
`ifdef EBPC_ZRLE_STATS_EN
        clr_stats_i = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #2;
        rst_ni = 1'b1;
        @(negedge clk);
        check("rst_vld", 32'(vld_o), 32'd0);
        check("rst_symb", 32'(symb_o), 32'd0);
        check("rst_len", 32'(len_o), 32'd0);
        check("rst_last", 32'(last_o), 32'd0);
        check("rst_rdy", 32'(rdy_o), 32'd1);
`ifdef EBPC_ZRLE_STATS_EN
        check("rst_nwords", n_words_o, 32'd0);
        check("rst_nbits", n_bits_o, 32'd0);
`endif
        @(posedge clk);
        #2;

        // Single literal with last: visible one cycle after acceptance.
        obs_q.delete();
        send(8'h05, 1'b1, w);
        check("s1_waits", 32'(w), 32'd0);
        idle(0);
        @(negedge clk);
        check("s1_vld", 32'(vld_o), 32'd1);
        check("s1_symb", 32'(symb_o), 32'h105);
        check("s1_len", 32'(len_o), 32'd9);
        check("s1_last", 32'(last_o), 32'd1);
        @(posedge clk);
        #2;
        idle(3);
        check("s1_count", 32'(obs_q.size()), 32'd1);

        // Three zeros then a literal with last.
`ifdef EBPC_ZRLE_STATS_EN
        clr_stats_i = 1'b1;
        @(posedge clk);
        #2;
        clr_stats_i = 1'b0;
`endif
        obs_q.delete();
        send(8'h00, 1'b0, w);
        send(8'h00, 1'b0, w);
        send(8'h00, 1'b0, w);
        send(8'h7F, 1'b1, w);
        check("s2_rdy_low", 32'(w), 32'd1);
        idle(4);
        check("s2_count", 32'(obs_q.size()), 32'd2);
        check("s2_sym0", 32'(obs_q[0]), 32'({9'h002, 4'd5, 1'b0}));
        check("s2_sym1", 32'(obs_q[1]), 32'({9'h17F, 4'd9, 1'b1}));
`ifdef EBPC_ZRLE_STATS_EN
        check("s2_nwords", n_words_o, 32'd4);
        check("s2_nbits", n_bits_o, 32'd14);
        clr_stats_i = 1'b1;
        @(posedge clk);
        #2;
        clr_stats_i = 1'b0;
        @(negedge clk);
        check("clr_nwords", n_words_o, 32'd0);
        check("clr_nbits", n_bits_o, 32'd0);
        @(posedge clk);
        #2;
`endif

        // Twenty zeros: a full run then a short run with last.
        obs_q.delete();
        for (int i = 0; i < 20; i++) send(8'h00, (i == 19), w);
        idle(4);
        check("s3_count", 32'(obs_q.size()), 32'd2);
        check("s3_sym0", 32'(obs_q[0]), 32'({9'h00F, 4'd5, 1'b0}));
        check("s3_sym1", 32'(obs_q[1]), 32'({9'h003, 4'd5, 1'b1}));

        // Literals under output back-pressure.
        obs_q.delete();
        rdy_i = 1'b0;
        send(8'h01, 1'b0, w);
        data_i = 8'h02;
        repeat (5) begin
            @(negedge clk);
            check("s4_vld", 32'(vld_o), 32'd1);
            check("s4_symb", 32'(symb_o), 32'h101);
            check("s4_rdy", 32'(rdy_o), 32'd0);
        end
        @(posedge clk);
        #2;
        rdy_i = 1'b1;
        send(8'h02, 1'b0, w);
        check("s4_tput2", 32'(w), 32'd0);
        send(8'h03, 1'b0, w);
        check("s4_tput3", 32'(w), 32'd0);
        send(8'h04, 1'b1, w);
        check("s4_tput4", 32'(w), 32'd0);
        idle(4);
        check("s4_count", 32'(obs_q.size()), 32'd4);
        check("s4_sym0", 32'(obs_q[0]), 32'({9'h101, 4'd9, 1'b0}));
        check("s4_sym1", 32'(obs_q[1]), 32'({9'h102, 4'd9, 1'b0}));
        check("s4_sym2", 32'(obs_q[2]), 32'({9'h103, 4'd9, 1'b0}));
        check("s4_sym3", 32'(obs_q[3]), 32'({9'h104, 4'd9, 1'b1}));

        // Reset in the middle of a run discards it.
        obs_q.delete();
        for (int i = 0; i < 7; i++) send(8'h00, 1'b0, w);
        idle(1);
        do_reset();
        send(8'h10, 1'b1, w);
        idle(4);
        check("s5_count", 32'(obs_q.size()), 32'd1);
        check("s5_sym0", 32'(obs_q[0]), 32'({9'h110, 4'd9, 1'b1}));

        // Randomised traffic against the model.
        rdy_rand = 1'b1;
        for (int i = 0; i < 2500; i++) begin
            logic [7:0] wd;
            bit         lt;
            if ($urandom_range(0, 3) == 0) idle(1);
            if ($urandom_range(0, 49) == 0) begin
                int n;
                n = $urandom_range(10, 40);
                for (int j = 0; j < n; j++) send(8'h00, 1'b0, w);
            end
            wd = ($urandom_range(0, 9) < 6) ? 8'd0 : 8'($urandom_range(1, 255));
            lt = ($urandom_range(0, 19) == 0);
            send(wd, lt, w);
        end
        send(8'h00, 1'b1, w);
        rdy_rand = 1'b0;
        rdy_i    = 1'b1;
        idle(8);
        check("end_queue_empty", 32'(exp_q.size()), 32'd0);
        check("end_run_flushed", 32'(run_cnt), 32'd0);
        check("end_vld", 32'(vld_o), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ebpc_zrle_encoder.md
Name: ebpc_zrle_encoder

Overview:
- Parametrised zero run-length encoder stage of the EBPC compressor.
- Consumes a stream of DATA_W-bit words and emits variable-length symbols:
  - literal: nonzero word
  - run: 1..MAX_ZRLE_LEN consecutive zero words
- Output is a symbol plus its bit length, consumed by the downstream bit-packer.
- Successor to the fixed 8-bit/16-run encoder. Width and maximum run are generic, with last-propagation and optional statistics.

Parameters:
- DATA_W, 8: input word width in bits, >=2.
- LOG_MAX_ZRLE_LEN, 4: log2 of the maximum zero run; MAX_ZRLE_LEN = 2**LOG_MAX_ZRLE_LEN.
- SYMB_W, DATA_W+1 (derived, not overridable): symbol bus width; must satisfy DATA_W >= LOG_MAX_ZRLE_LEN.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- data_i  in  DATA_W  input word
- last_i  in  1  marks final word of transfer
- vld_i  in  1  input valid
- rdy_o  out  1  input ready
- symb_o  out  SYMB_W  encoded symbol, right-aligned, MSB-first meaning
- len_o  out  $clog2(SYMB_W+1)  symbol length in bits
- last_o  out  1  final symbol of transfer
- vld_o  out  1  output valid
- rdy_i  in  1  output ready
- clr_stats_i  in  1  (EBPC_ZRLE_STATS_EN only) synchronous clear of the counters
- n_words_o  out  32  (EBPC_ZRLE_STATS_EN only) accepted input words
- n_bits_o  out  32  (EBPC_ZRLE_STATS_EN only) emitted symbol bits

Behaviour:
- Clock and reset: one clock, clk_i; asynchronous active-low reset rst_ni.
- Reset values:
  - FSM in IDLE, run counter 0.
  - vld_o=0, symb_o=0, len_o=0, last_o=0.
  - Stats counters 0.
- Encodings:
  - literal = {1'b1, word}, len DATA_W+1.
  - run of n zeros = {1'b0, (n-1) on LOG_MAX_ZRLE_LEN bits}, zero-extended to SYMB_W, len LOG_MAX_ZRLE_LEN+1.
- Output register: single stage. Loads when (!vld_o || rdy_i); "can_emit" denotes this condition.
- Handshakes: an input transfer occurs on vld_i && rdy_o; an output transfer on vld_o && rdy_i.
- Output stability: symb_o, len_o and last_o are held stable while vld_o && !rdy_i.
- IDLE state:
  - Zero word, not last: accept (rdy_o=1 regardless of can_emit), cnt<=1, go to RUN, no emission.
  - Zero word, last: requires can_emit; emit run n=1 with last_o=1; stay IDLE.
  - Nonzero word: requires can_emit; emit literal; last_o=last_i.
- RUN state (cnt in 1..MAX-1):
  - Zero word: requires can_emit if cnt+1==MAX or last_i.
    - cnt+1==MAX or last_i: emit run n=cnt+1 (last_o=last_i), go to IDLE.
    - Otherwise: cnt<=cnt+1, no emission.
  - Nonzero word: rdy_o=0 this cycle. If can_emit, emit run n=cnt (last_o=0) and go to IDLE; the literal follows in IDLE. The second symbol is never merged.
- Latency: a literal appears on vld_o one cycle after acceptance. No bubble between consecutive literals with rdy_i high.
- Last handling:
  - last_o is set on exactly one symbol per transfer.
  - After a last, the FSM is IDLE and cnt=0. A new transfer may start the next cycle.
- Reset mid-run discards the pending run count and any registered symbol.
- The counter never exceeds MAX. Run length MAX encodes as all-ones field.

Optional Feature:
- EBPC_ZRLE_STATS_EN defined:
  - Adds clr_stats_i, n_words_o and n_bits_o.
  - n_words_o increments per input transfer.
  - n_bits_o adds len_o per output transfer.
  - Both saturate at 2**32-1.
  - clr_stats_i has priority over increment.
- Undefined: these ports and registers do not exist; behaviour is otherwise identical.

Decomposition:
- ebpc_pkg gains:
  - zrle_state_t enum {IDLE, RUN}
  - function zrle_run_symb(n) returning the padded run field
  - localparam ZRLE_LEN_W
- Sub-module ebpc_sym_reg: a generic one-entry valid/ready register for {symb, len, last}. It is reused by the bit-plane encoder.

Test Plan (DATA_W=8, LOG_MAX_ZRLE_LEN=4):
- Single word 0x05 with last, rdy_i=1 -> one symbol 0x105, len 9, last_o=1, one cycle after acceptance.
- Words 0,0,0,0x7F(last) -> run 0x002 len 5, then 0x17F len 9 last. rdy_o low for exactly one cycle while 0x7F is presented.
- 20 zeros, last on the 20th -> 0x00F len 5, then 0x003 len 5 last_o=1. No other symbols.
- Literal stream 0x01..0x04 with rdy_i held 0 for 5 cycles -> vld_o high and 0x101 stable; rdy_o low. Full throughput resumes with no loss or duplication.
- rst_ni asserted after 7 zeros (RUN, cnt=7), then 0x10 last -> only 0x110 len 9 last is emitted. No stale run.
- With EBPC_ZRLE_STATS_EN, scenario 2 -> n_words_o=4, n_bits_o=14. clr_stats_i pulse -> both read 0 on the next cycle.
